// File: rtl/kf_pkg.sv
// kf_pkg: filter-format defaults, sequencer state type and the raw-to-fixed-point alignment helper
package kf_pkg;
  localparam int KF_WIDTH = 16;
  localparam int KF_INT_DIGITS = 8;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} seq_state_t;
  function automatic logic signed [63:0] sat_align(input logic signed [63:0] raw, input int in_frac, input int frac, input int width);
    logic signed [63:0] v, hi, lo;
    v = raw <<< (frac - in_frac);
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/kf_meas_sequencer_if.sv
// kf_meas_sequencer_if: valid/ready stream carrying one raw ADC sample set (inputs U, measurements Y)
interface kf_meas_sequencer_if #(
  parameter int noi = 1,
  parameter int noo = 1,
  parameter int ADC_W = 14
);
  logic s_valid;
  logic s_ready;
  logic [noi*ADC_W-1:0] s_u;
  logic [noo*ADC_W-1:0] s_y;
  modport master (output s_valid, s_u, s_y, input s_ready);
  modport slave (input s_valid, s_u, s_y, output s_ready);
endinterface

// File: rtl/kf_sample_fifo.sv
// kf_sample_fifo: synchronous sample-set buffer exposing full, empty and occupancy level
module kf_sample_fifo #(
  parameter int W = 28,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] level_q;
  logic do_push, do_pop;
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/kf_meas_sequencer.sv
// kf_meas_sequencer: buffers raw ADC sample sets, converts them to filter fixed point
// and paces the Kalman filter with one STEP_CYCLES-long enable burst per set
module kf_meas_sequencer import kf_pkg::*; #(
  parameter int WIDTH = KF_WIDTH,
  parameter int intDigits = KF_INT_DIGITS,
  parameter int noi = 1,
  parameter int noo = 1,
  parameter int ADC_W = 14,
  parameter int IN_FRAC = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int STEP_CYCLES = 64,
  localparam int FRAC = WIDTH - intDigits,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int CW = $clog2(STEP_CYCLES) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en_i,
  kf_meas_sequencer_if.slave        s_if,
  output logic [noi-1:0][WIDTH-1:0] u_o,
  output logic [noo-1:0][WIDTH-1:0] y_o,
  output logic                      kf_en_o,
  output logic                      busy_o,
  output logic                      starve_o,
  output logic [15:0]               step_cnt_o,
  output logic [LW-1:0]             fifo_level_o
);
  localparam int FW = (noi + noo) * ADC_W;
  seq_state_t state_q;
  logic [CW-1:0] cyc_q;
  logic [noi-1:0][WIDTH-1:0] u_q, u_d;
  logic [noo-1:0][WIDTH-1:0] y_q, y_d;
  logic [15:0] step_q;
  logic starve_q;
  logic [FW-1:0] fifo_dout;
  logic full, empty, last;
  kf_sample_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s_if.s_valid && s_if.s_ready),
    .pop_i   (clk_en_i && state_q == LOAD),
    .din_i   ({s_if.s_y, s_if.s_u}),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level_o)
  );
  assign s_if.s_ready = reset && !full;
  // head-of-FIFO conversion; only captured on LOAD so U/Y stay frozen through RUN
  for (genvar i = 0; i < noi; i++) begin : g_u
    assign u_d[i] = WIDTH'(sat_align(64'(signed'(fifo_dout[i*ADC_W +: ADC_W])), IN_FRAC, FRAC, WIDTH));
  end
  for (genvar i = 0; i < noo; i++) begin : g_y
    assign y_d[i] = WIDTH'(sat_align(64'(signed'(fifo_dout[(noi+i)*ADC_W +: ADC_W])), IN_FRAC, FRAC, WIDTH));
  end
  assign last = cyc_q == CW'(STEP_CYCLES - 1);
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      cyc_q <= '0;
      u_q <= '0;
      y_q <= '0;
      step_q <= '0;
      starve_q <= 1'b0;
    end else if (clk_en_i)
      case (state_q)
        IDLE: if (!empty) state_q <= LOAD;
        LOAD: begin
          u_q <= u_d;
          y_q <= y_d;
          cyc_q <= '0;
          state_q <= RUN;
        end
        RUN: if (last) begin
          step_q <= step_q + 16'd1;
          if (!empty) state_q <= LOAD;
          else begin
            state_q <= IDLE;
            if (step_q != '0) starve_q <= 1'b1;
          end
        end else cyc_q <= cyc_q + 1'b1;
        default: state_q <= IDLE;
      endcase
  assign u_o = u_q;
  assign y_o = y_q;
  assign kf_en_o = clk_en_i && state_q == RUN;
  assign busy_o = state_q != IDLE;
  assign starve_o = starve_q;
  assign step_cnt_o = step_q;
endmodule

// File: tb/tb_kf_meas_sequencer.sv
// tb_kf_meas_sequencer: directed vectors for conversion, step pacing, buffering, clk_en freeze and reset abort
module tb_kf_meas_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_en = 1'b1;
  always #5 clk = ~clk;
  kf_meas_sequencer_if #(.noi(1), .noo(1), .ADC_W(14)) sif();
  logic [0:0][15:0] u, y;
  logic kf_en, busy, starve;
  logic [15:0] step_cnt;
  logic [2:0] level;
  kf_meas_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en_i     (clk_en),
    .s_if         (sif),
    .u_o          (u),
    .y_o          (y),
    .kf_en_o      (kf_en),
    .busy_o       (busy),
    .starve_o     (starve),
    .step_cnt_o   (step_cnt),
    .fifo_level_o (level)
  );
  typedef struct {
    logic [13:0] su;
    logic [13:0] sy;
    logic [15:0] eu;
    logic [15:0] ey;
  } vec_t;
  vec_t vecs [6];
  int checks = 0;
  int errors = 0;
  int n, lows, exp_step;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [13:0] su, input logic [13:0] sy);
    int t;
    t = 0;
    sif.s_valid = 1'b1;
    sif.s_u = su;
    sif.s_y = sy;
    while (!sif.s_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("push_timeout", 32'(t), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rise(output int l);
    l = 0;
    while (!kf_en && l < 500) begin
      l++;
      @(negedge clk);
    end
    if (l >= 500) chk("rise_timeout", 32'(l), 0);
  endtask
  task automatic wait_step(input logic [15:0] eu, input logic [15:0] ey, input bit tog, output int cnt);
    int t;
    bit bad;
    logic [15:0] s0;
    t = 0;
    bad = 1'b0;
    s0 = step_cnt;
    cnt = 0;
    while (step_cnt == s0 && t < 2000) begin
      if (tog) begin
        clk_en = ~clk_en;
        #1;
      end
      if (kf_en) cnt++;
      if (u !== eu || y !== ey) bad = 1'b1;
      @(negedge clk);
      t++;
    end
    clk_en = 1'b1;
    if (t >= 2000) chk("step_timeout", 32'(t), 0);
    chk("uy_stable", 32'(bad), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{14'h0010, 14'h3FF0, 16'h0100, 16'hFF00};
    vecs[1] = '{14'h1FFF, 14'h2000, 16'h7FFF, 16'h8000};
    vecs[2] = '{14'h07FF, 14'h3800, 16'h7FF0, 16'h8000};
    vecs[3] = '{14'h0800, 14'h37FF, 16'h7FFF, 16'h8000};
    vecs[4] = '{14'h0000, 14'h0001, 16'h0000, 16'h0010};
    vecs[5] = '{14'h3FFF, 14'h0123, 16'hFFF0, 16'h1230};
    sif.s_valid = 1'b0;
    sif.s_u = '0;
    sif.s_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_kf_en", 32'(kf_en), 0);
    chk("rst_u", 32'(u), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_step", 32'(step_cnt), 0);
    chk("rst_starve", 32'(starve), 0);
    chk("rst_ready", 32'(sif.s_ready), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(sif.s_ready), 1);
    // reset abort at RUN cycle 30 with two sets still queued
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) push(vecs[k].su, vecs[k].sy);
    sif.s_valid = 1'b0;
    chk("abort_level3", 32'(level), 3);
    clk_en = 1'b1;
    wait_rise(lows);
    chk("abort_level2", 32'(level), 2);
    repeat (29) @(negedge clk);
    chk("abort_pre_kf_en", 32'(kf_en), 1);
    chk("abort_pre_u", 32'(u), 32'(vecs[0].eu));
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_kf_en", 32'(kf_en), 0);
    chk("abort_level", 32'(level), 0);
    chk("abort_u", 32'(u), 0);
    chk("abort_y", 32'(y), 0);
    chk("abort_step", 32'(step_cnt), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(sif.s_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready_rel", 32'(sif.s_ready), 1);
    @(negedge clk);
    exp_step = 0;
    // single-set steps: conversion, latency, burst length, starve rule
    for (int k = 0; k < 6; k++) begin
      push(vecs[k].su, vecs[k].sy);
      sif.s_valid = 1'b0;
      chk("xfer_kf_en", 32'(kf_en), 0);
      chk("xfer_level", 32'(level), 1);
      @(posedge clk);
      #1;
      chk("load_busy", 32'(busy), 1);
      chk("load_kf_en", 32'(kf_en), 0);
      @(posedge clk);
      #1;
      chk("run_kf_en", 32'(kf_en), 1);
      chk("vec_u", 32'(u), 32'(vecs[k].eu));
      chk("vec_y", 32'(y), 32'(vecs[k].ey));
      @(negedge clk);
      wait_step(vecs[k].eu, vecs[k].ey, 1'b0, n);
      exp_step++;
      chk("vec_en_cycles", 32'(n), 64);
      chk("vec_step_cnt", 32'(step_cnt), 32'(exp_step));
      chk("vec_idle", 32'(busy), 0);
      chk("vec_starve", 32'(starve), 32'(exp_step > 1));
    end
    // five sets back-to-back: fill with the FSM frozen, fifth waits for space
    clk_en = 1'b0;
    for (int k = 0; k < 4; k++) push(vecs[k].su, vecs[k].sy);
    chk("full_ready", 32'(sif.s_ready), 0);
    chk("full_level", 32'(level), 4);
    chk("frozen_busy", 32'(busy), 0);
    sif.s_u = vecs[4].su;
    sif.s_y = vecs[4].sy;
    fork
      begin
        @(negedge clk);
        for (int t = 0; t < 500 && !sif.s_ready; t++) @(negedge clk);
        @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
      end
    join_none
    clk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      wait_rise(lows);
      if (k > 0) chk("b2b_gap", 32'(lows), 1);
      chk("b2b_u", 32'(u), 32'(vecs[k].eu));
      chk("b2b_y", 32'(y), 32'(vecs[k].ey));
      wait_step(vecs[k].eu, vecs[k].ey, 1'b0, n);
      exp_step++;
      chk("b2b_en_cycles", 32'(n), 64);
      chk("b2b_step_cnt", 32'(step_cnt), 32'(exp_step));
    end
    chk("b2b_idle", 32'(busy), 0);
    chk("b2b_level", 32'(level), 0);
    chk("b2b_starve", 32'(starve), 1);
    // clk_en toggling during RUN
    push(vecs[5].su, vecs[5].sy);
    sif.s_valid = 1'b0;
    wait_rise(lows);
    wait_step(vecs[5].eu, vecs[5].ey, 1'b1, n);
    exp_step++;
    chk("tog_en_cycles", 32'(n), 64);
    chk("tog_step_cnt", 32'(step_cnt), 32'(exp_step));
    chk("tog_idle", 32'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
